// File: rtl/melody_sequencer.sv
// Plays an 8-note C4..C5 scale on a piezo buzzer: per-note half-period divider,
// duration counter and IDLE/TONE/GAP playback FSM. Optional MELODY_TEMPO_EN adds a tempo port.
module melody_sequencer #(
  parameter int unsigned NOTE_CYC = 12500000,
  parameter int unsigned GAP_CYC  = 1000000,
  parameter int unsigned LOOP     = 0
) (
  input  logic       clk_50MHz,
  input  logic       reset_button,
  input  logic       start,
  input  logic       stop,
`ifdef MELODY_TEMPO_EN
  input  logic [1:0] tempo,
`endif
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

  state_t      state;
  logic [16:0] tone_cnt;
  logic [31:0] dur_cnt;
  logic [31:0] tone_last;

  function automatic logic [16:0] half_period(input logic [2:0] idx);
    logic [16:0] n;
    case (idx)
      3'd0:    n = 17'd95554;
      3'd1:    n = 17'd85131;
      3'd2:    n = 17'd75842;
      3'd3:    n = 17'd71585;
      3'd4:    n = 17'd63775;
      3'd5:    n = 17'd56817;
      3'd6:    n = 17'd50618;
      default: n = 17'd47777;
    endcase
    return n;
  endfunction

`ifndef MELODY_TEMPO_EN
  assign tone_last = NOTE_LAST;
`endif

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      state    <= IDLE;
      buzzer   <= 1'b0;
      busy     <= 1'b0;
      note_idx <= '0;
      done     <= 1'b0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
`ifdef MELODY_TEMPO_EN
      tone_last <= NOTE_LAST;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        buzzer   <= 1'b0;
        busy     <= 1'b0;
        note_idx <= '0;
        tone_cnt <= '0;
        dur_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            buzzer <= 1'b0;
            busy   <= 1'b0;
            if (start) begin
              state    <= TONE;
              busy     <= 1'b1;
              note_idx <= '0;
              tone_cnt <= '0;
              dur_cnt  <= '0;
`ifdef MELODY_TEMPO_EN
              // Tempo is captured once per melody so later changes cannot stretch a note midway.
              tone_last <= (32'(NOTE_CYC) << tempo) - 32'd1;
`endif
            end
          end
          TONE: begin
            if (dur_cnt == tone_last) begin
              state    <= GAP;
              buzzer   <= 1'b0;
              dur_cnt  <= '0;
              tone_cnt <= '0;
            end else begin
              dur_cnt <= dur_cnt + 32'd1;
              if (tone_cnt == half_period(note_idx)) begin
                tone_cnt <= '0;
                buzzer   <= ~buzzer;
              end else begin
                tone_cnt <= tone_cnt + 17'd1;
              end
            end
          end
          GAP: begin
            buzzer <= 1'b0;
            if (dur_cnt == GAP_LAST) begin
              dur_cnt  <= '0;
              tone_cnt <= '0;
              if (note_idx != 3'd7) begin
                note_idx <= note_idx + 3'd1;
                state    <= TONE;
              end else if (LOOP != 0) begin
                note_idx <= '0;
                state    <= TONE;
              end else begin
                note_idx <= '0;
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              dur_cnt <= dur_cnt + 32'd1;
            end
          end
          default: begin
            state  <= IDLE;
            buzzer <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Downstream of the tone-divider stage: replaces its single fixed pitch with a sequenced 8-note melody driving the piezo buzzer.
- Steps through a fixed note table (C4..C5 scale). Each note plays for a programmable duration, then a short silent gap.
- Contains its own per-note half-period divider, duration counter and playback FSM.
- Sits between board push-buttons (start/stop) and the buzzer pin on the Spartan-6 edge board.

Parameters:
- NOTE_CYC, 12500000, cycles each note sounds (250 ms at 50 MHz).
- GAP_CYC, 1000000, cycles of silence after each note (20 ms).
- LOOP, 0, 1 = restart at note 0 after note 7; 0 = stop after note 7.

Ports:
- clk_50MHz  input  1  system clock, 50 MHz.
- reset_button  input  1  synchronous, active-high reset.
- start  input  1  level sampled each cycle; starts playback from IDLE.
- stop  input  1  level sampled each cycle; aborts playback from any state.
- buzzer  output  1  square-wave tone, registered.
- busy  output  1  high while in TONE or GAP.
- note_idx  output  3  index of the current note (0..7).
- done  output  1  one-cycle pulse when a non-looping melody completes.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk_50MHz. Next cycle: state IDLE, buzzer 0, busy 0, note_idx 0, done 0, all counters 0.
- Reset overrides start and stop.
- Note table: half-period terminal count N per index. Half period is N+1 cycles; buzzer toggles in the cycle after tone_cnt == N, and tone_cnt then clears.
  - 0 = C4 95554
  - 1 = D4 85131
  - 2 = E4 75842
  - 3 = F4 71585
  - 4 = G4 63775
  - 5 = A4 56817
  - 6 = B4 50618
  - 7 = C5 47777
- Widths: tone_cnt is 17 bits; dur_cnt is 32 bits. All compares are equality; there is no wrap-around within valid parameter ranges.
- FSM states: IDLE, TONE, GAP.
- IDLE:
  - buzzer 0, busy 0.
  - start=1 and stop=0 -> TONE next cycle, with note_idx 0, tone_cnt 0, dur_cnt 0, buzzer 0.
- TONE:
  - tone_cnt runs and buzzer toggles as above; dur_cnt increments every cycle.
  - When dur_cnt == NOTE_CYC-1 -> GAP next cycle, with buzzer forced 0 and dur_cnt cleared.
  - TONE therefore lasts exactly NOTE_CYC cycles.
- GAP:
  - buzzer held 0; dur_cnt increments every cycle.
  - When dur_cnt == GAP_CYC-1:
    - note_idx < 7 -> note_idx+1, TONE, tone_cnt 0, buzzer 0.
    - note_idx == 7 and LOOP=1 -> note_idx 0, TONE.
    - note_idx == 7 and LOOP=0 -> IDLE, with done=1 for exactly that first IDLE cycle and note_idx back to 0.
- Timing: busy rises the cycle after start is sampled. The first buzzer rising edge appears N+1 cycles after busy rises.
- stop=1 in TONE or GAP: next cycle IDLE, buzzer 0, busy 0, note_idx 0, no done pulse.
- start and stop high together: stop wins.
- start while busy: ignored; playback does not restart.
- Each note starts with buzzer 0 and tone_cnt 0, regardless of the previous note's phase.

Optional Feature:
- Macro: MELODY_TEMPO_EN.
- Defined:
  - Adds port tempo, input, 2 bits, latched in the cycle start is accepted.
  - TONE length becomes NOTE_CYC << tempo (x1, x2, x4, x8).
  - GAP length is unchanged. tempo changes during playback have no effect.
- Undefined: no tempo port; TONE length is always NOTE_CYC.

Test Plan:
- Reset: hold reset_button 3 cycles mid-TONE -> next cycle buzzer 0, busy 0, note_idx 0, done 0, and start is ignored while reset is high.
- Start, with NOTE_CYC=400000, GAP_CYC=1000, LOOP=0, one-cycle start pulse -> busy=1 next cycle; first buzzer rise 95555 cycles after busy; toggles every 95555 cycles; note_idx=1 exactly 401000 cycles after busy rose.
- Full melody, same parameters -> busy high for 3208000 cycles; done pulses exactly 1 cycle as busy falls; buzzer 0 in all GAP cycles; note 7 toggles every 47778 cycles.
- Stop: assert stop for 1 cycle during note 3 -> next cycle busy 0, buzzer 0, note_idx 0, no done. A new start replays from note 0.
- Loop, with LOOP=1 -> after note 7's gap, note_idx returns to 0 and TONE resumes the next cycle; no done pulse; busy stays 1 across 2 full passes.
- Collisions: start+stop together in IDLE -> stays IDLE. Start pulse during note 2 -> note_idx and dur_cnt unaffected.
